cpu_iu: RTL and testbench
=========================

Name: cpu_iu

Overview:
- Instruction unit sitting directly upstream of the execution unit.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ready handshake.
- Presents each instruction to the execution unit and control (bits [25:0] feed the EU; [31:26] feed control).
- Computes the next PC from the EU's Zero flag and sign-extended immediate when control signals that execution is complete.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- FETCH_TIMEOUT, 16, consecutive imem_ready-low cycles in FETCH that raise fault; range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  asynchronous active-low reset
- imem_addr  output  32  instruction memory address (equals pc)
- imem_req  output  1  fetch request, held until accepted
- imem_rdata  input  32  instruction word, valid when imem_ready=1
- imem_ready  input  1  memory accepts request and returns data this cycle
- exec_done  input  1  control: current instruction finished, advance PC
- branch  input  1  control: current instruction is a conditional branch (beq)
- jump  input  1  control: current instruction is j
- zero  input  1  Zero flag from execution unit
- seimm  input  32  sign-extended immediate from execution unit
- instruction  output  32  registered current instruction
- instr_valid  output  1  instruction is stable and may be executed
- pc  output  32  address of the current instruction
- fault  output  1  sticky fetch-timeout error

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=IDLE, pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, fault=0, wait counter=0.
  - Reset asserted mid-fetch or mid-issue aborts immediately, with no memory side effects.
- IDLE: one cycle after reset release, then FETCH unconditionally. The first imem_req is seen in the 2nd cycle after release.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On an edge with imem_ready=1: instruction<=imem_rdata, wait counter<=0, go to ISSUE. imem_ready in the same cycle req first rises gives a 1-cycle fetch.
  - On an edge with imem_ready=0: counter increments. When the counter reaches FETCH_TIMEOUT: go to FAULT, fault<=1.
- ISSUE:
  - imem_req=0, instr_valid=1; instruction and pc held stable.
  - exec_done=0: stay; this is the stall mechanism, with no limit.
  - exec_done=1: pc<=next_pc, go to FETCH. instr_valid drops the following cycle.
- FAULT:
  - imem_req=0, instr_valid=0, fault=1. Terminal until reset.
- Next-PC rule, evaluated in ISSUE only, arithmetic modulo 2^32:
  - pc4 = pc + 4.
  - jump=1: next_pc = {pc4[31:28], instruction[25:0], 2'b00}. Jump has priority over branch.
  - else branch=1 and zero=1: next_pc = pc4 + (seimm << 2). The shift discards seimm[31:30]; negative offsets wrap.
  - else: next_pc = pc4.
- Boundaries:
  - pc=32'hFFFF_FFFC sequential → 32'h0000_0000.
  - pc[1:0] is always 2'b00.
  - branch/jump/zero/seimm are ignored outside ISSUE and when exec_done=0.
  - exec_done in FETCH or IDLE is ignored.
  - imem_rdata is ignored unless imem_ready=1 in FETCH.
- Throughput: at best 2 cycles per instruction (FETCH 1, ISSUE 1).

Decomposition:
- Shared package cpu_pkg:
  - state encoding IU_IDLE/IU_FETCH/IU_ISSUE/IU_FAULT (2-bit).
  - PC_INCR=32'd4.
  - opcode field positions [31:26], [25:0].
- One combinational sub-module, next_pc_logic, with inputs pc, instruction[25:0], seimm, branch, jump, zero and output next_pc. It is unit-testable on its own.
- FSM, wait counter and registers stay in cpu_iu.

Test Plan:
- Reset and sequential fetch: RESET_PC=0, ready always 1, exec_done pulses in each ISSUE → imem_addr sequence 0,4,8,C; instr_valid high 1 cycle in 2; first req at cycle 2.
- Taken branch: pc=0x100, branch=1, zero=1, seimm=0xFFFF_FFFE at exec_done → next imem_addr=0x0FC. Same case with zero=0 → 0x104.
- Jump priority: pc=0x4000_0010, instruction[25:0]=0x0000040, jump=1, branch=1, zero=1 → next imem_addr=0x4000_0100.
- Memory wait and stall:
  - imem_ready low for 5 cycles, then high with rdata=0x2002_0005 → instruction=0x2002_0005, fault=0.
  - Holding exec_done=0 for 10 cycles keeps pc and instruction unchanged, instr_valid=1.
- Timeout: FETCH_TIMEOUT=4, ready held low → fault=1 after 4 waiting edges, imem_req=0 thereafter. reset_n low mid-FAULT → pc=RESET_PC, fault=0, async (no clock edge needed).
- Wrap and async abort:
  - pc=0xFFFF_FFFC, sequential → imem_addr=0x0000_0000.
  - reset_n pulsed low between edges during FETCH → imem_req drops immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction unit: state encoding,
// PC increment and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IU_IDLE  = 2'd0,
    IU_FETCH = 2'd1,
    IU_ISSUE = 2'd2,
    IU_FAULT = 2'd3
  } iu_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  // Opcode goes to control, the low field goes to the execution unit
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [TARGET_MSB-TARGET_LSB:0] target_of(input logic [31:0] instr);
    return instr[TARGET_MSB:TARGET_LSB];
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential, taken beq, or j.
// Jump wins over branch; all arithmetic wraps modulo 2^32.
module next_pc_logic
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_target,
  input  logic [31:0] seimm,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  // Pick the successor address; the seimm shift drops bits [31:30] by design
  always_comb begin
    pc4 = pc + PC_INCR;
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr_target, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + {seimm[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/cpu_iu.sv
// Instruction unit: holds the PC, fetches over a req/ready handshake,
// presents the instruction until exec_done, then advances the PC.
// A fetch that waits FETCH_TIMEOUT edges parks the unit in FAULT.
module cpu_iu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] seimm,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        fault
);

  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  iu_state_e   state;
  iu_state_e   state_next;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt == WAIT_LAST);
  assign imem_addr   = pc;

  next_pc_logic u_next_pc (
    .pc           (pc),
    .instr_target (target_of(instruction)),
    .seimm        (seimm),
    .branch       (branch),
    .jump         (jump),
    .zero         (zero),
    .next_pc      (next_pc)
  );

  // State register, cleared asynchronously so reset aborts any fetch at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision from handshake, timeout and exec_done
  always_comb begin
    state_next = state;
    case (state)
      IU_IDLE:  state_next = IU_FETCH;
      IU_FETCH: begin
        if (imem_ready) begin
          state_next = IU_ISSUE;
        end else if (timeout_hit) begin
          state_next = IU_FAULT;
        end
      end
      IU_ISSUE: begin
        if (exec_done) begin
          state_next = IU_FETCH;
        end
      end
      IU_FAULT: state_next = IU_FAULT;
      default:  state_next = IU_IDLE;
    endcase
  end

  // Handshake and valid outputs decode directly from the state
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IU_FETCH: imem_req    = 1'b1;
      IU_ISSUE: instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  // Datapath registers: instruction capture, wait counter, PC update, sticky fault
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      instruction <= 32'h0;
      wait_cnt    <= 8'h0;
      fault       <= 1'b0;
    end else begin
      case (state)
        IU_FETCH: begin
          if (imem_ready) begin
            instruction <= imem_rdata;
            wait_cnt    <= 8'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) begin
              fault <= 1'b1;
            end
          end
        end
        IU_ISSUE: begin
          wait_cnt <= 8'h0;
          if (exec_done) begin
            pc <= {next_pc[31:2], 2'b00};
          end
        end
        default: begin
          wait_cnt <= wait_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_iu.sv
// Self-checking bench for cpu_iu: a transaction-level PC model drives
// randomized fetch waits, stalls and control, plus a second instance
// with a short timeout for the fault path.
module tb_cpu_iu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        exec_done;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] seimm;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fault;

  logic        to_reset_n;
  logic        to_ready;
  logic [31:0] to_addr;
  logic        to_req;
  logic [31:0] to_instr;
  logic        to_valid;
  logic [31:0] to_pc;
  logic        to_fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc;

  always #5 clk = ~clk;

  cpu_iu #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .exec_done(exec_done),
    .branch(branch), .jump(jump), .zero(zero), .seimm(seimm),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc), .fault(fault)
  );

  cpu_iu #(.RESET_PC(RESET_PC), .FETCH_TIMEOUT(4)) dut_to (
    .clk(clk), .reset_n(to_reset_n), .imem_addr(to_addr), .imem_req(to_req),
    .imem_rdata(imem_rdata), .imem_ready(to_ready), .exec_done(exec_done),
    .branch(branch), .jump(jump), .zero(zero), .seimm(seimm),
    .instruction(to_instr), .instr_valid(to_valid), .pc(to_pc), .fault(to_fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Successor address straight from the ISA rules
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input logic [31:0] imm, input logic br,
                                             input logic jp, input logic zr);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((word % 32'h0400_0000) * 32'd4);
    if (br && zr) return seq + imm * 32'd4;
    return seq;
  endfunction

  task automatic noise();
    branch     = 1'($urandom);
    jump       = 1'($urandom);
    zero       = 1'($urandom);
    seimm      = $urandom;
    imem_rdata = $urandom;
  endtask

  // One full instruction: wait_n refused fetch edges, stall_n held ISSUE edges, then retire
  task automatic applyStimulus(input logic [31:0] word, input int wait_n, input int stall_n,
                               input logic br, input logic jp, input logic zr,
                               input logic [31:0] imm);
    logic [31:0] expect_next;
    for (int i = 0; i < wait_n; i++) begin
      noise();
      imem_ready = 1'b0;
      exec_done  = 1'($urandom);
      checkOutput("wait_req", imem_req, 1);
      checkOutput("wait_addr", imem_addr, model_pc);
      checkOutput("wait_valid", instr_valid, 0);
      tick();
    end
    exec_done  = 1'($urandom);
    imem_ready = 1'b1;
    imem_rdata = word;
    checkOutput("fetch_req", imem_req, 1);
    checkOutput("fetch_addr", imem_addr, model_pc);
    tick();
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    noise();
    checkOutput("issue_valid", instr_valid, 1);
    checkOutput("issue_instr", instruction, word);
    checkOutput("issue_pc", pc, model_pc);
    checkOutput("issue_req", imem_req, 0);
    checkOutput("issue_fault", fault, 0);
    for (int i = 0; i < stall_n; i++) begin
      noise();
      exec_done = 1'b0;
      tick();
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_instr", instruction, word);
      checkOutput("stall_pc", pc, model_pc);
    end
    exec_done   = 1'b1;
    branch      = br;
    jump        = jp;
    zero        = zr;
    seimm       = imm;
    expect_next = model_next(model_pc, word, imm, br, jp, zr);
    tick();
    exec_done = 1'b0;
    model_pc  = expect_next;
    checkOutput("next_addr", imem_addr, model_pc);
    checkOutput("next_valid", instr_valid, 0);
    checkOutput("next_req", imem_req, 1);
  endtask

  // Steer the model and DUT to an arbitrary target with one taken branch
  task automatic gotoPc(input logic [31:0] target);
    logic [31:0] imm;
    imm = (target - (model_pc + 32'd4)) >> 2;
    applyStimulus($urandom, 0, 0, 1'b1, 1'b0, 1'b1, imm);
    checkOutput("goto_addr", imem_addr, target);
  endtask

  initial begin
    reset_n    = 1'b0;
    to_reset_n = 1'b0;
    imem_ready = 1'b0;
    to_ready   = 1'b0;
    imem_rdata = 32'h0;
    exec_done  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    zero       = 1'b0;
    seimm      = 32'h0;
    model_pc   = RESET_PC;
    #1;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_instr", instruction, 0);
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_fault", fault, 0);
    tick();
    tick();
    reset_n = 1'b1;
    checkOutput("idle_req", imem_req, 0);
    tick();
    checkOutput("first_req", imem_req, 1);
    checkOutput("first_addr", imem_addr, RESET_PC);

    // Back-to-back sequential fetches: 0, 4, 8, C
    for (int i = 0; i < 4; i++) applyStimulus($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("seq_addr", imem_addr, 32'h10);

    // Taken and untaken branch from 0x100
    applyStimulus(32'h0800_0040, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("jump_0x100", imem_addr, 32'h100);
    applyStimulus($urandom, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    checkOutput("branch_taken", imem_addr, 32'h0FC);
    applyStimulus(32'h0800_0040, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus($urandom, 0, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    checkOutput("branch_untaken", imem_addr, 32'h104);

    // Jump has priority over a taken branch
    gotoPc(32'h4000_0010);
    applyStimulus(32'h0800_0040, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0010);
    checkOutput("jump_priority", imem_addr, 32'h4000_0100);

    // Slow memory then a long stall
    applyStimulus(32'h2002_0005, 5, 10, 1'b0, 1'b0, 1'b0, 32'h0);

    // Sequential wrap at the top of the address space
    gotoPc(32'hFFFF_FFFC);
    applyStimulus($urandom, 1, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom, int'($urandom_range(0, 8)), int'($urandom_range(0, 4)),
                    1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                    32'($urandom_range(0, 64)) - 32'd32);
      checkOutput("rand_align", {30'h0, imem_addr[1:0]}, 0);
    end

    // Asynchronous abort in the middle of a fetch
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort_req", imem_req, 0);
    checkOutput("abort_pc", pc, RESET_PC);
    checkOutput("abort_valid", instr_valid, 0);
    tick();
    reset_n  = 1'b1;
    model_pc = RESET_PC;
    checkOutput("abort_idle_req", imem_req, 0);
    tick();
    checkOutput("abort_refetch", imem_addr, RESET_PC);
    applyStimulus($urandom, 2, 1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Fetch timeout on the short-timeout instance
    to_reset_n = 1'b1;
    to_ready   = 1'b0;
    tick();
    checkOutput("to_req", to_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("to_wait_fault", to_fault, 0);
      checkOutput("to_wait_req", to_req, 1);
    end
    tick();
    checkOutput("to_fault", to_fault, 1);
    checkOutput("to_fault_req", to_req, 0);
    to_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("to_sticky", to_fault, 1);
      checkOutput("to_sticky_req", to_req, 0);
      checkOutput("to_sticky_valid", to_valid, 0);
    end
    #2 to_reset_n = 1'b0;
    #1;
    checkOutput("to_rst_fault", to_fault, 0);
    checkOutput("to_rst_pc", to_pc, RESET_PC);
    checkOutput("to_rst_req", to_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
